neo_outport_sync: RTL and testbench

Synchronous, parametrised successor to the 68K-side output/bank latch of the D0 I/O chip. It samples the asynchronous 68K write strobe on the system clock, decodes a four-entry register map and drives a configurable number of output ports plus a bank register. Each port can run in level mode (value held) or pulse mode (value auto-clears after a programmable number of clock-enable ticks). It sits beside the clock divider and Z80 controller, feeding controller-select outputs and the memory-card bank lines.

---
 rtl/neo_outport_sync.sv | 123 ++++++++++++
 tb/tb_neo_outport_sync.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/neo_outport_sync.sv
// rtl/neo_outport_sync.sv - 68K output/bank latch with strobe synchronizer and pulse-mode ports
module neo_outport_sync #(
  parameter int NUM_PORTS = 2,
  parameter int PORT_W    = 3,
  parameter int BNK_W     = 3,
  parameter int PULSE_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        clk_en_i,
  input  logic                        nbitwd0_i,
  input  logic [1:0]                  m68k_addr_i,
  input  logic [7:0]                  m68k_data_i,
  output logic [NUM_PORTS*PORT_W-1:0] p_out_o,
  output logic [BNK_W-1:0]            bnk_o,
  output logic                        wr_stb_o,
  output logic                        busy_o
);

  // Strobe synchronizer and the address/data pipeline that tracks it
  logic                 s1_q, s2_q, s3_q;
  logic [1:0]           addr_s1_q, addr_s2_q;
  logic [7:0]           data_s1_q, data_s2_q;
  logic                 commit_d, commit_q;
  logic [1:0]           cmd_addr_q;
  logic [7:0]           cmd_data_q;

  // Register file
  logic [BNK_W-1:0]     bnk_q;
  logic [NUM_PORTS-1:0] mode_q;
  logic [PULSE_W-1:0]   plen_q;
  logic                 wr_stb_q;
  logic [PORT_W-1:0]    port_q [NUM_PORTS];
  logic [PULSE_W-1:0]   cnt_q  [NUM_PORTS];

  logic                 wr_out, wr_bnk, wr_mode, wr_plen;

  // Falling edge of the strobe as seen after two synchronizing flops
  assign commit_d = ~s2_q & s3_q;

  // Sample strobe, address and data; addr/data age alongside s1->s2 so the
  // captured copy is the one sampled on the edge that first saw the strobe low
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      addr_s1_q  <= '0;
      addr_s2_q  <= '0;
      data_s1_q  <= '0;
      data_s2_q  <= '0;
      commit_q   <= 1'b0;
      cmd_addr_q <= '0;
      cmd_data_q <= '0;
    end else begin
      s1_q      <= nbitwd0_i;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      addr_s1_q <= m68k_addr_i;
      addr_s2_q <= addr_s1_q;
      data_s1_q <= m68k_data_i;
      data_s2_q <= data_s1_q;
      commit_q  <= commit_d;
      if (commit_d) begin
        cmd_addr_q <= addr_s2_q;
        cmd_data_q <= data_s2_q;
      end
    end
  end

  assign wr_out  = commit_q && (cmd_addr_q == 2'd0);
  assign wr_bnk  = commit_q && (cmd_addr_q == 2'd1);
  assign wr_mode = commit_q && (cmd_addr_q == 2'd2);
  assign wr_plen = commit_q && (cmd_addr_q == 2'd3);

  // Apply committed writes and run the per-port pulse counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      bnk_q    <= '0;
      mode_q   <= '0;
      plen_q   <= '0;
      wr_stb_q <= 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        port_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
    end else begin
      wr_stb_q <= commit_q;
      if (wr_bnk)  bnk_q  <= cmd_data_q[BNK_W-1:0];
      if (wr_mode) mode_q <= cmd_data_q[NUM_PORTS-1:0];
      if (wr_plen) plen_q <= PULSE_W'(cmd_data_q);
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (wr_out) begin
          // A commit beats a coincident tick: reload without decrementing
          port_q[i] <= cmd_data_q[i*PORT_W +: PORT_W];
          cnt_q[i]  <= mode_q[i] ? plen_q : '0;
        end else if (wr_mode && !cmd_data_q[i]) begin
          // Leaving pulse mode stops the counter but keeps the value
          cnt_q[i] <= '0;
        end else if (clk_en_i && (cnt_q[i] != '0)) begin
          cnt_q[i] <= cnt_q[i] - PULSE_W'(1);
          if (cnt_q[i] == PULSE_W'(1)) port_q[i] <= '0;
        end
      end
    end
  end

  // Any running counter means a pulse is still in flight
  always_comb begin
    busy_o = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      busy_o = busy_o | (cnt_q[i] != '0);
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign p_out_o[g*PORT_W +: PORT_W] = port_q[g];
  end

  assign bnk_o    = bnk_q;
  assign wr_stb_o = wr_stb_q;

endmodule

// File: tb/tb_neo_outport_sync.sv
// tb/tb_neo_outport_sync.sv - directed self-checking bench for neo_outport_sync
module tb_neo_outport_sync;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_en;
  logic       nb;
  logic [1:0] addr;
  logic [7:0] data;

  logic [5:0] p_out_a;
  logic [2:0] bnk_a;
  logic       wr_stb_a, busy_a;
  logic [7:0] p_out_b;
  logic [2:0] bnk_b;
  logic       wr_stb_b, busy_b;
  logic [7:0] p_out_c;
  logic [2:0] bnk_c;
  logic       wr_stb_c, busy_c;

  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  neo_outport_sync #(.NUM_PORTS(2), .PORT_W(3), .BNK_W(3), .PULSE_W(8)) dut_a (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .nbitwd0_i(nb),
    .m68k_addr_i(addr), .m68k_data_i(data),
    .p_out_o(p_out_a), .bnk_o(bnk_a), .wr_stb_o(wr_stb_a), .busy_o(busy_a));

  neo_outport_sync #(.NUM_PORTS(1), .PORT_W(8), .BNK_W(3), .PULSE_W(8)) dut_b (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .nbitwd0_i(nb),
    .m68k_addr_i(addr), .m68k_data_i(data),
    .p_out_o(p_out_b), .bnk_o(bnk_b), .wr_stb_o(wr_stb_b), .busy_o(busy_b));

  neo_outport_sync #(.NUM_PORTS(8), .PORT_W(1), .BNK_W(3), .PULSE_W(8)) dut_c (
    .clk_i(clk), .reset_i(reset), .clk_en_i(clk_en), .nbitwd0_i(nb),
    .m68k_addr_i(addr), .m68k_data_i(data),
    .p_out_o(p_out_c), .bnk_o(bnk_c), .wr_stb_o(wr_stb_c), .busy_o(busy_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Strobe low for 'low' cycles then high for 4; counts WR_STB samples
  task automatic wr(input logic [1:0] a, input logic [7:0] d, input int low, output int cnt);
    cnt  = 0;
    addr = a;
    data = d;
    nb   = 1'b0;
    for (int i = 0; i < low; i++) begin
      tick();
      if (wr_stb_a) cnt++;
    end
    nb = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (wr_stb_a) cnt++;
    end
  endtask

  initial begin
    reset  = 1'b1;
    clk_en = 1'b0;
    nb     = 1'b1;
    addr   = 2'd0;
    data   = 8'h00;
    tick(); tick(); tick();
    chk("reset_p_out", 32'(p_out_a), 32'h0);
    chk("reset_bnk", 32'(bnk_a), 32'h0);
    chk("reset_wr_stb", 32'(wr_stb_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);

    // Strobe held low across reset release must not commit
    nb = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin tick(); if (wr_stb_a) n++; end
    nb = 1'b1;
    for (int i = 0; i < 5; i++) begin tick(); if (wr_stb_a) n++; end
    chk("held_strobe_no_commit", 32'(n), 32'h0);
    chk("held_strobe_p_out", 32'(p_out_a), 32'h0);

    // Exact latency of an OUT write, plus bit mapping of the swept variants
    addr = 2'd0; data = 8'h2D; nb = 1'b0;
    tick();
    nb = 1'b1;
    tick(); tick();
    chk("lat_k2_wr_stb", 32'(wr_stb_a), 32'h0);
    chk("lat_k2_p_out", 32'(p_out_a), 32'h0);
    tick();
    chk("lat_k3_wr_stb", 32'(wr_stb_a), 32'h1);
    chk("lat_k3_p_out", 32'(p_out_a), 32'h2D);
    chk("sweep_1x8_p_out", 32'(p_out_b), 32'h2D);
    chk("sweep_8x1_p_out", 32'(p_out_c), 32'h2D);
    tick();
    chk("wr_stb_one_wide", 32'(wr_stb_a), 32'h0);

    // Long strobe, bank write
    wr(2'd1, 8'hFE, 20, n);
    chk("long_strobe_one_stb", 32'(n), 32'h1);
    chk("bnk_write", 32'(bnk_a), 32'h6);
    chk("bnk_keeps_p_out", 32'(p_out_a), 32'h2D);

    // Pulse mode on port 0, PLEN=4
    wr(2'd2, 8'h01, 2, n);
    wr(2'd3, 8'h04, 2, n);
    wr(2'd0, 8'h3F, 2, n);
    chk("pulse_start_busy", 32'(busy_a), 32'h1);
    chk("pulse_start_p_out", 32'(p_out_a), 32'h3F);
    clk_en = 1'b1;
    tick(); tick(); tick();
    chk("pulse_tick3_p_out", 32'(p_out_a), 32'h3F);
    chk("pulse_tick3_busy", 32'(busy_a), 32'h1);
    tick();
    chk("pulse_tick4_p_out", 32'(p_out_a), 32'h38);
    chk("pulse_tick4_busy", 32'(busy_a), 32'h0);
    clk_en = 1'b0;

    // OUT commit coinciding with a tick while cnt=2: reload, no decrement
    wr(2'd0, 8'h3F, 2, n);
    clk_en = 1'b1;
    tick(); tick();
    clk_en = 1'b0;
    addr = 2'd0; data = 8'h3D; nb = 1'b0;
    tick();
    nb = 1'b1;
    tick(); tick();
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    chk("reload_p_out", 32'(p_out_a), 32'h3D);
    chk("reload_busy", 32'(busy_a), 32'h1);
    clk_en = 1'b1;
    tick(); tick(); tick();
    chk("reload_tick3_p_out", 32'(p_out_a), 32'h3D);
    tick();
    chk("reload_tick4_p_out", 32'(p_out_a), 32'h38);
    clk_en = 1'b0;

    // Leaving pulse mode mid-pulse holds the value
    wr(2'd0, 8'h3F, 2, n);
    clk_en = 1'b1;
    tick();
    clk_en = 1'b0;
    wr(2'd2, 8'h00, 2, n);
    chk("mode_clear_busy", 32'(busy_a), 32'h0);
    clk_en = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    clk_en = 1'b0;
    chk("mode_clear_hold_p_out", 32'(p_out_a), 32'h3F);
    chk("mode_clear_hold_busy", 32'(busy_a), 32'h0);

    // Reset mid-pulse
    wr(2'd2, 8'h01, 2, n);
    wr(2'd0, 8'h3A, 2, n);
    clk_en = 1'b1;
    tick();
    chk("pre_reset_busy", 32'(busy_a), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_reset_p_out", 32'(p_out_a), 32'h0);
    chk("mid_reset_bnk", 32'(bnk_a), 32'h0);
    chk("mid_reset_busy", 32'(busy_a), 32'h0);
    for (int i = 0; i < 5; i++) tick();
    chk("post_reset_p_out", 32'(p_out_a), 32'h0);
    clk_en = 1'b0;

    // PLEN=0 in pulse mode holds indefinitely
    wr(2'd2, 8'h01, 2, n);
    wr(2'd0, 8'h15, 2, n);
    chk("plen0_busy", 32'(busy_a), 32'h0);
    chk("plen0_p_out", 32'(p_out_a), 32'h15);
    clk_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    clk_en = 1'b0;
    chk("plen0_hold_p_out", 32'(p_out_a), 32'h15);
    chk("plen0_hold_busy", 32'(busy_a), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
